// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: op codes and controller states.
package seq_alu_pkg;

  localparam logic [2:0] OP_PASS_A   = 3'd0;
  localparam logic [2:0] OP_PASS_B   = 3'd1;
  localparam logic [2:0] OP_ADD      = 3'd2;
  localparam logic [2:0] OP_SUB      = 3'd3;
  localparam logic [2:0] OP_ACC_ADD  = 3'd4;
  localparam logic [2:0] OP_ACC_LOAD = 3'd5;
  localparam logic [2:0] OP_MUL      = 3'd6;
  localparam logic [2:0] OP_RSVD     = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_alu_mul.sv
// Shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
// done is asserted during the final step and product already includes that
// step's partial product, so the caller can register the result on the same edge.
module seq_alu_mul
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] sum_next;

  // Partial-product accumulation; only the low WIDTH bits are ever needed.
  always_comb begin
    sum_next = sum_reg + (mplier_reg[0] ? mcand_reg : '0);
  end

  assign done    = (count_reg == CW'(1));
  assign product = sum_next;

  // Load operands on start, then shift one multiplier bit per cycle until the count runs out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      sum_reg    <= '0;
      count_reg  <= '0;
    end else if (start) begin
      mcand_reg  <= a;
      mplier_reg <= b;
      sum_reg    <= '0;
      count_reg  <= CW'(WIDTH);
    end else if (count_reg != '0) begin
      sum_reg    <= sum_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      count_reg  <= count_reg - CW'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes on both sides, an internal
// accumulator and a multi-cycle multiplier. Results and flags are held
// in DONE until the consumer takes them.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y,
  output logic             is_zero,
  output logic             carry,
  output logic             overflow,
  output logic             err,
  output logic             out_valid,
  input  logic             out_ready
);

  state_t           state_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] y_reg;
  logic             carry_reg;
  logic             overflow_reg;
  logic             err_reg;
  logic             out_valid_reg;

  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [WIDTH:0]   acc_ext;
  logic [WIDTH-1:0] res_y;
  logic             res_c;
  logic             res_v;
  logic             res_e;

  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign in_ready  = (state_reg == ST_IDLE);
  assign mul_start = in_valid && (state_reg == ST_IDLE) && (op == OP_MUL);

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle result and flags for every op except MUL.
  always_comb begin
    add_ext = {1'b0, a} + {1'b0, b};
    sub_ext = {1'b0, a} - {1'b0, b};
    acc_ext = {1'b0, acc_reg} + {1'b0, a};
    res_y   = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    res_e   = 1'b0;
    case (op)
      OP_PASS_A:   res_y = a;
      OP_PASS_B:   res_y = b;
      OP_ADD: begin
        res_y = add_ext[WIDTH-1:0];
        res_c = add_ext[WIDTH];
        res_v = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_y = sub_ext[WIDTH-1:0];
        res_c = (a < b);
        res_v = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_ACC_ADD: begin
        res_y = acc_ext[WIDTH-1:0];
        res_c = acc_ext[WIDTH];
        res_v = (acc_reg[WIDTH-1] == a[WIDTH-1]) && (acc_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_ACC_LOAD: res_y = a;
      OP_RSVD:     res_e = 1'b1;
      default:     res_y = '0;
    endcase
  end

  // Controller: accept in IDLE, wait out the multiplier in BUSY, hold results in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      acc_reg       <= '0;
      y_reg         <= '0;
      carry_reg     <= 1'b0;
      overflow_reg  <= 1'b0;
      err_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            if (op == OP_MUL) begin
              state_reg <= ST_BUSY;
            end else begin
              y_reg         <= res_y;
              carry_reg     <= res_c;
              overflow_reg  <= res_v;
              err_reg       <= res_e;
              out_valid_reg <= 1'b1;
              state_reg     <= ST_DONE;
              if (op == OP_ACC_ADD || op == OP_ACC_LOAD) begin
                acc_reg <= res_y;
              end
            end
          end
        end
        ST_BUSY: begin
          if (mul_done) begin
            y_reg         <= mul_product;
            carry_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
            err_reg       <= 1'b0;
            out_valid_reg <= 1'b1;
            state_reg     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign y         = y_reg;
  assign is_zero   = (y_reg == '0);
  assign carry     = carry_reg;
  assign overflow  = overflow_reg;
  assign err       = err_reg;
  assign out_valid = out_valid_reg;

endmodule
